cpu_boot_ctrl: RTL and testbench

Sequencer that owns the pipelined CPU's program-load and run cycle. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into instruction memory at consecutive addresses. It then holds the CPU in reset for a fixed number of cycles, releases it for a programmed number of run cycles, and parks it back in reset. It replaces manual toggling of LoadInstructions/Reset and sits between the host/bench and the CPU's instruction-memory write port and reset input.

---
 rtl/cpu_boot_ctrl_pkg.sv | 19 +
 rtl/cpu_boot_ctrl_counter.sv | 30 +++
 rtl/cpu_boot_ctrl.sv | 146 ++++++++++++++
 tb/tb_cpu_boot_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared types and constants for the CPU boot/load sequencer.
// Optional NOP fill of unused instruction memory: define BOOT_CTRL_NOP_FILL_EN.
package boot_ctrl_pkg;

  localparam int unsigned RUN_W    = 16;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
`ifdef BOOT_CTRL_NOP_FILL_EN
    ST_FILL,
`endif
    ST_HOLD,
    ST_RUN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cpu_boot_ctrl_counter.sv
// Loadable down counter with zero flag; one instance is reused for the
// reset-hold interval and the run interval.
module boot_down_counter
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned W = RUN_W
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cpu_boot_ctrl.sv
// Program-load and run sequencer for the pipelined CPU: streams words into
// instruction memory, holds CPU reset, runs for a latched cycle count, parks.
// Optional NOP fill of the memory tail after a short load: BOOT_CTRL_NOP_FILL_EN.
module cpu_boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              load_start,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              instr_valid,
  input  logic [31:0]       instr_data,
  input  logic              instr_last,
  output logic              instr_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [RUN_W-1:0]  HOLD_LOAD = RUN_W'(RST_HOLD - 1);

  state_t r_state, w_next;

  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic [RUN_W-1:0]  r_run_cycles;
  logic              r_instr_ready, r_imem_we, r_cpu_rst, r_busy, r_done;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;

  logic              w_accept, w_final, w_start;
  logic              w_we;
  logic [31:0]       w_wdata;
  logic              w_cnt_load, w_cnt_dec, w_cnt_zero;
  logic [RUN_W-1:0]  w_cnt_val;

  assign w_accept = instr_valid && r_instr_ready;
  assign w_final  = w_accept && (instr_last || (r_ptr == LAST_ADDR));
  assign w_start  = load_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (load_start) w_next = ST_LOAD;
      ST_LOAD: begin
        if (w_final) begin
`ifdef BOOT_CTRL_NOP_FILL_EN
          // an overflow stop has no tail left to fill
          w_next = (r_ptr == LAST_ADDR) ? ST_HOLD : ST_FILL;
`else
          w_next = ST_HOLD;
`endif
        end
      end
`ifdef BOOT_CTRL_NOP_FILL_EN
      ST_FILL: if (r_ptr == LAST_ADDR) w_next = ST_HOLD;
`endif
      ST_HOLD: if (w_cnt_zero) w_next = (r_run_cycles == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_cnt_zero) w_next = ST_DONE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we    = w_accept;
    w_wdata = instr_data;
`ifdef BOOT_CTRL_NOP_FILL_EN
    if (r_state == ST_FILL) begin
      w_we    = 1'b1;
      w_wdata = NOP_WORD;
    end
`endif
    // counter holds (cycles-1) so the zero flag marks the interval's last cycle
    w_cnt_load = ((w_next == ST_HOLD) && (r_state != ST_HOLD)) ||
                 ((r_state == ST_HOLD) && (w_next == ST_RUN));
    w_cnt_val  = (r_state == ST_HOLD) ? (r_run_cycles - RUN_W'(1)) : HOLD_LOAD;
    w_cnt_dec  = (r_state == ST_HOLD) || (r_state == ST_RUN);
  end

  boot_down_counter #(
    .W (RUN_W)
  ) u_cnt (
    .clk        (clk),
    .Reset      (Reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_instr_ready <= 1'b0;
      r_imem_we     <= 1'b0;
      r_imem_addr   <= '0;
      r_imem_wdata  <= '0;
      r_cpu_rst     <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_ptr         <= '0;
      r_word_count  <= '0;
      r_run_cycles  <= '0;
    end else begin
      r_instr_ready <= (w_next == ST_LOAD);
      r_cpu_rst     <= (w_next != ST_RUN);
      r_busy        <= !((w_next == ST_IDLE) || (w_next == ST_DONE));
      r_done        <= (w_next == ST_DONE);
      r_imem_we     <= w_we;
      if (w_we) begin
        r_imem_addr  <= r_ptr;
        r_imem_wdata <= w_wdata;
      end
      if (w_start) begin
        r_ptr        <= '0;
        r_word_count <= '0;
        r_run_cycles <= run_cycles;
      end else begin
        if (w_we)     r_ptr        <= r_ptr + 1'b1;
        if (w_accept) r_word_count <= r_word_count + 1'b1;
      end
    end
  end

  assign instr_ready = r_instr_ready;
  assign imem_we     = r_imem_we;
  assign imem_addr   = r_imem_addr;
  assign imem_wdata  = r_imem_wdata;
  assign cpu_rst     = r_cpu_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign word_count  = r_word_count;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: a 64-word instance and an 8-word instance
// (overflow and tail-fill cases); expectations adapt to BOOT_CTRL_NOP_FILL_EN.
module tb_cpu_boot_ctrl;

  localparam int unsigned AW  = 6;
  localparam int unsigned SAW = 3;
  localparam int unsigned RH  = 2;
`ifdef BOOT_CTRL_NOP_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          load_start, instr_valid, instr_last, instr_ready;
  logic [15:0]   run_cycles;
  logic [31:0]   instr_data, imem_wdata;
  logic          imem_we, cpu_rst, busy, done;
  logic [AW-1:0] imem_addr;
  logic [AW:0]   word_count;

  logic           s_load_start, s_instr_valid, s_instr_last, s_instr_ready;
  logic [15:0]    s_run_cycles;
  logic [31:0]    s_instr_data, s_imem_wdata;
  logic           s_imem_we, s_cpu_rst, s_busy, s_done;
  logic [SAW-1:0] s_imem_addr;
  logic [SAW:0]   s_word_count;

  cpu_boot_ctrl #(.ADDR_W(AW), .RST_HOLD(RH)) u_dut (
    .clk(clk), .Reset(rst), .load_start(load_start), .run_cycles(run_cycles),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_last(instr_last),
    .instr_ready(instr_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_rst(cpu_rst), .busy(busy), .done(done),
    .word_count(word_count)
  );

  cpu_boot_ctrl #(.ADDR_W(SAW), .RST_HOLD(RH)) u_dut_small (
    .clk(clk), .Reset(rst), .load_start(s_load_start), .run_cycles(s_run_cycles),
    .instr_valid(s_instr_valid), .instr_data(s_instr_data), .instr_last(s_instr_last),
    .instr_ready(s_instr_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr),
    .imem_wdata(s_imem_wdata), .cpu_rst(s_cpu_rst), .busy(s_busy), .done(s_done),
    .word_count(s_word_count)
  );

  // write logs and CPU-run cycle counters, sampled mid-cycle
  logic [AW-1:0]  wr_addr[$];
  logic [31:0]    wr_data[$];
  logic [SAW-1:0] s_wr_addr[$];
  logic [31:0]    s_wr_data[$];
  int unsigned    low_cnt = 0;
  int unsigned    s_low_cnt = 0;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (s_imem_we === 1'b1) begin
      s_wr_addr.push_back(s_imem_addr);
      s_wr_data.push_back(s_imem_wdata);
    end
    if (cpu_rst === 1'b0)   low_cnt++;
    if (s_cpu_rst === 1'b0) s_low_cnt++;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic start(input logic [15:0] rc);
    load_start = 1'b1;
    run_cycles = rc;
    @(negedge clk);
    load_start = 1'b0;
    run_cycles = 16'hFFFF;
  endtask

  task automatic send(input logic [31:0] d, input logic last, output bit ok);
    ok = 1'b0;
    instr_valid = 1'b1;
    instr_data  = d;
    instr_last  = last;
    for (int t = 0; t < 20; t++) begin
      if (instr_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    instr_last  = 1'b0;
  endtask

  task automatic s_send(input logic [31:0] d, input logic last, output bit ok);
    ok = 1'b0;
    s_instr_valid = 1'b1;
    s_instr_data  = d;
    s_instr_last  = last;
    for (int t = 0; t < 5; t++) begin
      if (s_instr_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s_instr_valid = 1'b0;
    s_instr_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while ((done !== 1'b1) && (cyc < 300)) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, done, 1'b1);
  endtask

  task automatic s_wait_done(input string tag);
    int cyc;
    cyc = 0;
    while ((s_done !== 1'b1) && (cyc < 100)) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, s_done, 1'b1);
  endtask

  initial begin
    int          base_w, base_l, cyc, nacc;
    bit          ok, all_ok;

    rst = 1'b1;
    load_start = 1'b0; run_cycles = '0; instr_valid = 1'b0; instr_data = '0; instr_last = 1'b0;
    s_load_start = 1'b0; s_run_cycles = '0; s_instr_valid = 1'b0; s_instr_data = '0; s_instr_last = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_ready", instr_ready, 1'b0);
    check("rst_we",    imem_we,     1'b0);
    check("rst_addr",  imem_addr,   '0);
    check("rst_wdata", imem_wdata,  '0);
    check("rst_cpu",   cpu_rst,     1'b1);
    check("rst_busy",  busy,        1'b0);
    check("rst_done",  done,        1'b0);
    check("rst_wc",    word_count,  '0);
    rst = 1'b0;
    @(negedge clk);

    // 11-word load, 20 run cycles, stray load_start during RUN
    base_w = wr_addr.size(); base_l = low_cnt;
    start(16'd20);
    check("t1_busy",  busy,        1'b1);
    check("t1_ready", instr_ready, 1'b1);
    all_ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(32'hA500_0000 | i, (i == 10), ok);
      all_ok &= ok;
    end
    check("t1_accept",     all_ok,      1'b1);
    check("t1_ready_drop", instr_ready, 1'b0);
    check("t1_wc",         word_count,  7'd11);
    cyc = 0;
    while ((cpu_rst !== 1'b0) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    check("t1_run_start", cpu_rst, 1'b0);
    load_start = 1'b1; run_cycles = 16'd5;
    @(negedge clk);
    load_start = 1'b0;
    check("t1_ignore_wc", word_count, 7'd11);
    wait_done("t1_done", cyc);
    check("t1_run_len", low_cnt - base_l, 20);
    check("t1_cpu_rst", cpu_rst, 1'b1);
    check("t1_idle",    busy,    1'b0);
    check("t1_nwr",     wr_addr.size() - base_w, FILL ? 64 : 11);
    for (int i = 0; i < 11; i++) begin
      check("t1_addr", wr_addr[base_w + i], i);
      check("t1_data", wr_data[base_w + i], 32'hA500_0000 | i);
    end
    repeat (3) @(negedge clk);
    check("t1_done_held", done, 1'b1);

    // gapped valid, 4 words, 3 run cycles
    base_w = wr_addr.size(); base_l = low_cnt;
    start(16'd3);
    check("t2_done_clr", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(32'h0000_1000 + i, (i == 3), ok);
      check("t2_accept", ok, 1'b1);
      if (i < 3) @(negedge clk);
    end
    wait_done("t2_done", cyc);
    check("t2_nwr",     wr_addr.size() - base_w, FILL ? 64 : 4);
    for (int i = 0; i < 4; i++) begin
      check("t2_addr", wr_addr[base_w + i], i);
      check("t2_data", wr_data[base_w + i], 32'h0000_1000 + i);
    end
    check("t2_run_len", low_cnt - base_l, 3);
    check("t2_wc",      word_count, 7'd4);

    // run_cycles = 0: CPU never released
    base_l = low_cnt;
    start(16'd0);
    send(32'hC0DE_0000, 1'b0, ok);
    send(32'hC0DE_0001, 1'b1, ok);
    wait_done("t3_done", cyc);
    check("t3_latency", cyc + 1, FILL ? (64 - 2 + RH + 1) : (RH + 1));
    check("t3_no_run",  low_cnt - base_l, 0);

    // reset during RUN, then a fresh load
    start(16'd20);
    send(32'hDEAD_BEEF, 1'b1, ok);
    cyc = 0;
    while ((cpu_rst !== 1'b0) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    repeat (5) @(negedge clk);
    check("t4_running", cpu_rst, 1'b0);
    rst = 1'b1;
    #1;
    check("t4_cpu_rst", cpu_rst,     1'b1);
    check("t4_busy",    busy,        1'b0);
    check("t4_done",    done,        1'b0);
    check("t4_wc",      word_count,  '0);
    check("t4_ready",   instr_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base_l = low_cnt;
    start(16'd2);
    send(32'h1234_5678, 1'b1, ok);
    check("t4_accept", ok, 1'b1);
    wait_done("t4_done2", cyc);
    check("t4_run_len", low_cnt - base_l, 2);
    check("t4_wc2",     word_count, 7'd1);

    // 8-word instance: stream 10 words without last
    base_w = s_wr_addr.size(); base_l = s_low_cnt;
    s_load_start = 1'b1; s_run_cycles = 16'd1;
    @(negedge clk);
    s_load_start = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      s_send(32'hB0 + i, 1'b0, ok);
      if (ok) nacc++;
    end
    check("t5_nacc",  nacc, 8);
    check("t5_ready", s_instr_ready, 1'b0);
    check("t5_wc",    s_word_count, 4'd8);
    s_wait_done("t5_done");
    check("t5_run_len", s_low_cnt - base_l, 1);
    check("t5_nwr",     s_wr_addr.size() - base_w, 8);
    for (int i = 0; i < 8; i++) begin
      check("t5_addr", s_wr_addr[base_w + i], i);
      check("t5_data", s_wr_data[base_w + i], 32'hB0 + i);
    end

    // 8-word instance: short 3-word load (tail fill when enabled)
    base_w = s_wr_addr.size();
    s_load_start = 1'b1; s_run_cycles = 16'd1;
    @(negedge clk);
    s_load_start = 1'b0;
    for (int i = 0; i < 3; i++) s_send(32'hE0 + i, (i == 2), ok);
    s_wait_done("t6_done");
    check("t6_wc",  s_word_count, 4'd3);
    check("t6_nwr", s_wr_addr.size() - base_w, FILL ? 8 : 3);
    for (int i = 0; i < 3; i++) begin
      check("t6_addr", s_wr_addr[base_w + i], i);
      check("t6_data", s_wr_data[base_w + i], 32'hE0 + i);
    end
    for (int i = 3; i < (s_wr_addr.size() - base_w); i++) begin
      check("t6_fill_addr", s_wr_addr[base_w + i], i);
      check("t6_fill_data", s_wr_data[base_w + i], 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
